vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Pixel-timing and output stage that sits directly upstream of the game-logic wrapper's video outputs. It derives the pixel clock enable and the `clk_div` strobe from the system clock, and runs the horizontal/vertical counters for an 800x525 raster. It drives `hpos`/`vpos`/`display_on` to the game logic and registers the returned colour with hsync/vsync, so the frame-capture bench sees aligned, blanked `hsync`/`vsync`/`rgb`, sampled on rising `clk_div`.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel; even, >=2
SYNC_POL, 0, active level of hsync/vsync

Ports:
clk         in   1   system clock
reset       in   1   synchronous, active-high reset
rgb_in      in   3   colour from game logic for current hpos/vpos (combinational)
clk_div     out  1   pixel-rate strobe, 50% duty; outputs stable at its rising edge
pix_en      out  1   one-clk pulse per pixel; counters/outputs advance on this edge
hpos        out  10  current horizontal count, 0..H_TOTAL-1
vpos        out  10  current vertical count, 0..V_TOTAL-1
display_on  out  1   hpos<H_DISPLAY && vpos<V_DISPLAY
frame_start out  1   one-clk pulse, pix_en cycle with hpos==0 && vpos==0
frame_cnt   out  16  completed-frame counter, wraps at 2^16
hsync       out  1   registered horizontal sync
vsync       out  1   registered vertical sync
rgb         out  3   registered, blanked colour

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
- Divider:
  - div_cnt runs 0..CLK_DIV-1, wraps.
  - pix_en = (div_cnt == CLK_DIV-1), combinational.
  - clk_div registered: 0 while next div_cnt < CLK_DIV/2, else 1.
  - clk_div falls on the edge where outputs update and rises CLK_DIV/2 clks later.
- Raster counters: on each clk edge with pix_en=1:
  - hpos increments.
  - At H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - vpos wraps to 0 after V_TOTAL-1; on that same edge frame_cnt increments.
- Sync windows (pre-delay), asserted at SYNC_POL, otherwise ~SYNC_POL:
  - hsync_d when hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync_d when vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- Output stage: on each pix_en edge:
  - rgb <= display_on ? rgb_in : 3'b000.
  - hsync <= hsync_d; vsync <= vsync_d.
  - Latency is exactly one pixel from hpos/vpos to hsync/vsync/rgb, so the three outputs stay mutually aligned.
- Holding: between pix_en edges all registered outputs and counters hold.
- Reset (synchronous, has priority over pix_en):
  - div_cnt=0, hpos=0, vpos=0, frame_cnt=0, clk_div=0, rgb=0.
  - hsync=vsync=~SYNC_POL.
  - First pix_en is CLK_DIV-1 clks after reset deasserts.
  - Reset mid-frame restarts the raster at (0,0) with no partial-state carry-over.
- frame_start:
  - Combinational: pix_en && hpos==0 && vpos==0.
  - Its first occurrence is the first pix_en after reset.
- Arithmetic:
  - All compares are unsigned, 10-bit.
  - Totals >1024 are unsupported; elaboration-time check.
  - An odd CLK_DIV or CLK_DIV<2 is an elaboration error.

Test Plan:
- Reset: assert reset 7 clks -> hsync=vsync=1, rgb=0, hpos=vpos=0, clk_div=0, frame_cnt=0; first pix_en exactly 1 clk after release (CLK_DIV=2).
- Line timing, defaults: count clk_div rises -> 800 per line; hsync low for exactly 96 consecutive rises, first low output pixel index 656; line period 1600 clks.
- Frame timing: run 2 frames -> frame period 840000 clks; vsync low for 1600 consecutive pixel clocks (lines 490-491); frame_start pulses once per frame; frame_cnt=2.
- Blanking: rgb_in=3'b111 constant -> rgb=111 on 640 pixels/line for 480 lines (307200 per frame), 0 elsewhere; rgb_in=3'b101 driven only when hpos==0 -> rgb=101 on output pixel 0 only (one-pixel latency).
- Reset mid-frame: assert reset at vpos=200, hpos=300 for 1 clk -> next pix_en shows hpos=0, vpos=0; frame_cnt=0; outputs idle values.
- CLK_DIV=4: clk_div period 4 clks, high 2; pix_en every 4th clk; line period 3200 clks; outputs constant across each clk_div rise.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video bus between the timing generator and the game logic / capture side
//
// Purpose: carries the raster position, blanking and registered sync/colour
// outputs of vga_timing_gen together with the colour returned by game logic.
//
// Signals:
//   rgb_in      colour from game logic for the current hpos/vpos (combinational)
//   clk_div     pixel-rate strobe, 50% duty, outputs stable at its rising edge
//   pix_en      one-clk pulse per pixel; counters/outputs advance on this edge
//   hpos, vpos  raster position
//   display_on  high inside the visible area
//   frame_start one-clk pulse on the pix_en cycle at (0,0)
//   frame_cnt   completed-frame counter
//   hsync/vsync registered syncs, aligned with rgb
//   rgb         registered, blanked colour
//
// Modports: master = timing generator, slave = game logic / capture.

interface vga_timing_gen_if;
  logic [2:0]  rgb_in;
  logic        clk_div;
  logic        pix_en;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;

  modport master (
    input  rgb_in,
    output clk_div, pix_en, hpos, vpos, display_on, frame_start,
           frame_cnt, hsync, vsync, rgb
  );

  modport slave (
    output rgb_in,
    input  clk_div, pix_en, hpos, vpos, display_on, frame_start,
           frame_cnt, hsync, vsync, rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel divider, raster counters and registered VGA output stage
//
// Purpose: divides the system clock down to the pixel rate, runs the
// horizontal/vertical raster counters, hands hpos/vpos/display_on to the game
// logic and registers the returned colour together with hsync/vsync so all
// three video outputs carry the same one-pixel latency.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; has priority over pix_en
//   vga    vga_timing_gen_if.master (see interface for the signal list)

module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int SYNC_POL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  // Counters are 10 bits wide and the divider must split evenly into a
  // 50% duty strobe, so reject anything else at elaboration.
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_en;
  logic             clk_div_q;

  logic [9:0]  hpos_q;
  logic [9:0]  vpos_q;
  logic [15:0] frame_cnt_q;
  logic        display_on;
  logic        hsync_d;
  logic        vsync_d;
  logic        hsync_q;
  logic        vsync_q;
  logic [2:0]  rgb_q;

  assign pix_en  = (div_cnt == DIV_LAST);
  assign div_nxt = pix_en ? '0 : div_cnt + DIV_W'(1);

  // clk_div is decoded from the next divider value so it falls on the same
  // edge that updates the outputs and rises half a pixel later, giving the
  // capture side a full half-period of setup.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      clk_div_q <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      clk_div_q <= (div_nxt >= DIV_HALF);
    end
  end

  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  assign hsync_d    = ((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
  assign vsync_d    = ((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;

  // Raster counters and output registers share the pix_en edge; the output
  // registers capture the decode of the current position, so sync and colour
  // trail hpos/vpos by exactly one pixel and stay mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      frame_cnt_q <= '0;
      rgb_q       <= 3'b000;
      hsync_q     <= ~SYNC_ACT;
      vsync_q     <= ~SYNC_ACT;
    end else if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_q <= '0;
        if (vpos_q == V_LAST) begin
          vpos_q      <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          vpos_q <= vpos_q + 10'd1;
        end
      end else begin
        hpos_q <= hpos_q + 10'd1;
      end
      rgb_q   <= display_on ? vga.rgb_in : 3'b000;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.clk_div     = clk_div_q;
  assign vga.pix_en      = pix_en;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.display_on  = display_on;
  assign vga.frame_start = pix_en && (hpos_q == 10'd0) && (vpos_q == 10'd0);
  assign vga.frame_cnt   = frame_cnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
//
// Three instances share clk/reset: u_def (default 800x525 raster),
// u_sm (16x12 raster, SYNC_POL=1, for frame-level scenarios) and
// u_d4 (default raster, CLK_DIV=4).

module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rgb_const = 3'b000;
  logic       rgb_mode = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if v_def ();
  vga_timing_gen_if v_sm ();
  vga_timing_gen_if v_d4 ();

  assign v_def.rgb_in = rgb_const;
  assign v_d4.rgb_in  = rgb_const;
  assign v_sm.rgb_in  = rgb_mode ? ((v_sm.hpos == 10'd0) ? 3'b101 : 3'b000) : rgb_const;

  vga_timing_gen u_def (.clk(clk), .reset(reset), .vga(v_def));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(2), .SYNC_POL(1)
  ) u_sm (.clk(clk), .reset(reset), .vga(v_sm));

  vga_timing_gen #(.CLK_DIV(4)) u_d4 (.clk(clk), .reset(reset), .vga(v_d4));

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int wait_c;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    n_checks++; if (v_def.hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", v_def.hsync); end
    n_checks++; if (v_def.vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", v_def.vsync); end
    n_checks++; if (v_def.rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b expected 000", v_def.rgb); end
    n_checks++; if (v_def.hpos !== 10'd0 || v_def.vpos !== 10'd0) begin n_fail++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", v_def.hpos, v_def.vpos); end
    n_checks++; if (v_def.clk_div !== 1'b0) begin n_fail++; $display("FAIL reset_clk_div: got %b expected 0", v_def.clk_div); end
    n_checks++; if (v_def.frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", v_def.frame_cnt); end
    n_checks++; if (v_def.pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en: got %b expected 0", v_def.pix_en); end
    n_checks++; if (v_sm.hsync !== 1'b0 || v_sm.vsync !== 1'b0) begin n_fail++; $display("FAIL reset_sync_pol1: got %b%b expected 00", v_sm.hsync, v_sm.vsync); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (v_def.pix_en !== 1'b1) begin n_fail++; $display("FAIL first_pix_en: got %b expected 1", v_def.pix_en); end
    n_checks++; if (v_def.frame_start !== 1'b1) begin n_fail++; $display("FAIL first_frame_start: got %b expected 1", v_def.frame_start); end
    n_checks++; if (v_def.clk_div !== 1'b1) begin n_fail++; $display("FAIL first_clk_div_rise: got %b expected 1", v_def.clk_div); end
    wait_c = 1;
    while (v_d4.pix_en !== 1'b1 && wait_c < 20) begin
      @(posedge clk);
      #1;
      wait_c++;
    end
    n_checks++; if (wait_c != 3) begin n_fail++; $display("FAIL div4_first_pix_en: got %0d clks expected 3", wait_c); end
  endtask

  task automatic test_line();
    logic prev;
    int r, c_first, c_second, mis_pos, lo_first, lo_last, lo_cnt, vis_cnt, rgb_bad, vs_bad;
    rgb_const = 3'b111;
    rgb_mode  = 1'b0;
    do_reset(3);
    prev = 1'b0; r = 0; c_first = 0; c_second = 0; mis_pos = 0;
    lo_first = -1; lo_last = -1; lo_cnt = 0; vis_cnt = 0; rgb_bad = 0; vs_bad = 0;
    for (int c = 1; c <= 3210; c++) begin
      @(posedge clk);
      #1;
      if (v_def.hpos !== 10'((c / 2) % 800) || v_def.vpos !== 10'((c / 2) / 800)) mis_pos++;
      if (v_def.clk_div === 1'b1 && prev === 1'b0) begin
        r++;
        if (r == 1) c_first = c;
        if (r == 801) c_second = c;
        if (r >= 2 && r <= 801) begin
          if (v_def.hsync === 1'b0) begin
            lo_cnt++;
            if (lo_first < 0) lo_first = r - 2;
            lo_last = r - 2;
          end
          if (v_def.rgb === 3'b111) vis_cnt++;
          else if (v_def.rgb !== 3'b000) rgb_bad++;
        end
        if (v_def.vsync !== 1'b1) vs_bad++;
      end
      prev = v_def.clk_div;
    end
    n_checks++; if (mis_pos != 0) begin n_fail++; $display("FAIL line_pos_track: got %0d mismatching clks expected 0", mis_pos); end
    n_checks++; if (r != 1605) begin n_fail++; $display("FAIL line_rise_count: got %0d expected 1605", r); end
    n_checks++; if (c_second - c_first != 1600) begin n_fail++; $display("FAIL line_period: got %0d clks expected 1600", c_second - c_first); end
    n_checks++; if (lo_cnt != 96) begin n_fail++; $display("FAIL hsync_width: got %0d expected 96", lo_cnt); end
    n_checks++; if (lo_first != 656) begin n_fail++; $display("FAIL hsync_first: got %0d expected 656", lo_first); end
    n_checks++; if (lo_last != 751) begin n_fail++; $display("FAIL hsync_last: got %0d expected 751", lo_last); end
    n_checks++; if (vis_cnt != 640) begin n_fail++; $display("FAIL line_visible: got %0d expected 640", vis_cnt); end
    n_checks++; if (rgb_bad != 0) begin n_fail++; $display("FAIL line_rgb_other: got %0d expected 0", rgb_bad); end
    n_checks++; if (vs_bad != 0) begin n_fail++; $display("FAIL line_vsync_idle: got %0d expected 0", vs_bad); end
  endtask

  task automatic test_frame();
    logic prev;
    int r, fs_n, vs_cnt, vs_first, vs_last, hs_cnt;
    int fs_c [3];
    logic [15:0] fc_383, fc_384, fc_768;
    rgb_const = 3'b000;
    do_reset(3);
    prev = 1'b0; r = 0; fs_n = 0; vs_cnt = 0; vs_first = -1; vs_last = -1; hs_cnt = 0;
    fs_c = '{0, 0, 0};
    fc_383 = 16'hFFFF; fc_384 = 16'hFFFF; fc_768 = 16'hFFFF;
    for (int c = 1; c <= 770; c++) begin
      @(posedge clk);
      #1;
      if (v_sm.frame_start === 1'b1) begin
        if (fs_n < 3) fs_c[fs_n] = c;
        fs_n++;
      end
      if (c == 383) fc_383 = v_sm.frame_cnt;
      if (c == 384) fc_384 = v_sm.frame_cnt;
      if (c == 768) fc_768 = v_sm.frame_cnt;
      if (v_sm.clk_div === 1'b1 && prev === 1'b0) begin
        r++;
        if (r >= 2 && r <= 193) begin
          if (v_sm.vsync === 1'b1) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = r - 2;
            vs_last = r - 2;
          end
          if (v_sm.hsync === 1'b1) hs_cnt++;
        end
      end
      prev = v_sm.clk_div;
    end
    n_checks++; if (fs_n != 3) begin n_fail++; $display("FAIL frame_start_count: got %0d expected 3", fs_n); end
    n_checks++; if (fs_c[1] - fs_c[0] != 384 || fs_c[2] - fs_c[1] != 384) begin n_fail++; $display("FAIL frame_period: got %0d,%0d expected 384,384", fs_c[1] - fs_c[0], fs_c[2] - fs_c[1]); end
    n_checks++; if (fc_383 !== 16'd0 || fc_384 !== 16'd1) begin n_fail++; $display("FAIL frame_cnt_wrap_edge: got %0d,%0d expected 0,1", fc_383, fc_384); end
    n_checks++; if (fc_768 !== 16'd2) begin n_fail++; $display("FAIL frame_cnt_two: got %0d expected 2", fc_768); end
    n_checks++; if (vs_cnt != 32 || vs_first != 128 || vs_last != 159) begin n_fail++; $display("FAIL vsync_window: got cnt %0d first %0d last %0d expected 32 128 159", vs_cnt, vs_first, vs_last); end
    n_checks++; if (hs_cnt != 36) begin n_fail++; $display("FAIL frame_hsync_count: got %0d expected 36", hs_cnt); end
  endtask

  task automatic test_blanking();
    logic prev;
    int r, vis_cnt, rgb_bad, hit_cnt;
    logic [2:0] px7, px8, px87, px96, px0, px16;
    rgb_const = 3'b111;
    rgb_mode  = 1'b0;
    do_reset(3);
    prev = 1'b0; r = 0; vis_cnt = 0; rgb_bad = 0;
    px7 = 3'bxxx; px8 = 3'bxxx; px87 = 3'bxxx; px96 = 3'bxxx;
    for (int c = 1; c <= 386; c++) begin
      @(posedge clk);
      #1;
      if (v_sm.clk_div === 1'b1 && prev === 1'b0) begin
        r++;
        if (r >= 2 && r <= 193) begin
          if (v_sm.rgb === 3'b111) vis_cnt++;
          else if (v_sm.rgb !== 3'b000) rgb_bad++;
          if (r - 2 == 7)  px7  = v_sm.rgb;
          if (r - 2 == 8)  px8  = v_sm.rgb;
          if (r - 2 == 87) px87 = v_sm.rgb;
          if (r - 2 == 96) px96 = v_sm.rgb;
        end
      end
      prev = v_sm.clk_div;
    end
    n_checks++; if (vis_cnt != 48) begin n_fail++; $display("FAIL blank_visible_count: got %0d expected 48", vis_cnt); end
    n_checks++; if (rgb_bad != 0) begin n_fail++; $display("FAIL blank_other_colour: got %0d expected 0", rgb_bad); end
    n_checks++; if (px7 !== 3'b111 || px8 !== 3'b000) begin n_fail++; $display("FAIL blank_h_edge: got %b,%b expected 111,000", px7, px8); end
    n_checks++; if (px87 !== 3'b111 || px96 !== 3'b000) begin n_fail++; $display("FAIL blank_v_edge: got %b,%b expected 111,000", px87, px96); end

    rgb_mode = 1'b1;
    do_reset(3);
    prev = 1'b0; r = 0; hit_cnt = 0; px0 = 3'bxxx; px16 = 3'bxxx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (v_sm.clk_div === 1'b1 && prev === 1'b0) begin
        r++;
        if (r == 2) px0 = v_sm.rgb;
        if (r == 18) px16 = v_sm.rgb;
        if (r >= 3 && r <= 17 && v_sm.rgb !== 3'b000) hit_cnt++;
      end
      prev = v_sm.clk_div;
    end
    rgb_mode = 1'b0;
    n_checks++; if (px0 !== 3'b101) begin n_fail++; $display("FAIL latency_px0: got %b expected 101", px0); end
    n_checks++; if (hit_cnt != 0) begin n_fail++; $display("FAIL latency_others: got %0d nonzero expected 0", hit_cnt); end
    n_checks++; if (px16 !== 3'b101) begin n_fail++; $display("FAIL latency_next_line: got %b expected 101", px16); end
  endtask

  task automatic test_mid_reset();
    rgb_const = 3'b111;
    do_reset(3);
    for (int c = 1; c <= 663; c++) @(posedge clk);
    #1;
    n_checks++; if (v_sm.hpos !== 10'd11 || v_sm.vpos !== 10'd8 || v_sm.frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_precond: got %0d,%0d,%0d expected 11,8,1", v_sm.hpos, v_sm.vpos, v_sm.frame_cnt); end
    n_checks++; if (v_sm.hsync !== 1'b1 || v_sm.vsync !== 1'b1) begin n_fail++; $display("FAIL mid_precond_sync: got %b%b expected 11", v_sm.hsync, v_sm.vsync); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (v_sm.hpos !== 10'd0 || v_sm.vpos !== 10'd0 || v_sm.frame_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d,%0d,%0d expected 0,0,0", v_sm.hpos, v_sm.vpos, v_sm.frame_cnt); end
    n_checks++; if (v_sm.hsync !== 1'b0 || v_sm.vsync !== 1'b0 || v_sm.rgb !== 3'b000 || v_sm.clk_div !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got %b%b %b %b expected 00 000 0", v_sm.hsync, v_sm.vsync, v_sm.rgb, v_sm.clk_div); end
    @(posedge clk);
    #1;
    n_checks++; if (v_sm.pix_en !== 1'b1 || v_sm.frame_start !== 1'b1 || v_sm.hpos !== 10'd0 || v_sm.vpos !== 10'd0) begin n_fail++; $display("FAIL mid_restart: got pix_en %b fs %b pos %0d,%0d expected 1 1 0,0", v_sm.pix_en, v_sm.frame_start, v_sm.hpos, v_sm.vpos); end
  endtask

  task automatic test_clkdiv4();
    logic prev, prev_hs;
    logic [9:0] prev_h;
    logic [2:0] prev_rgb;
    int r, c_first, c_second, mis_div, mis_pix, mis_pos, mis_stab;
    rgb_const = 3'b111;
    do_reset(3);
    prev = 1'b0; prev_hs = v_d4.hsync; prev_h = v_d4.hpos; prev_rgb = v_d4.rgb;
    r = 0; c_first = 0; c_second = 0; mis_div = 0; mis_pix = 0; mis_pos = 0; mis_stab = 0;
    for (int c = 1; c <= 3210; c++) begin
      @(posedge clk);
      #1;
      if (v_d4.clk_div !== ((c % 4 == 2) || (c % 4 == 3))) mis_div++;
      if (v_d4.pix_en !== (c % 4 == 3)) mis_pix++;
      if (v_d4.hpos !== 10'((c / 4) % 800) || v_d4.vpos !== 10'((c / 4) / 800)) mis_pos++;
      if (v_d4.clk_div === 1'b1 && prev === 1'b0) begin
        r++;
        if (r == 1) c_first = c;
        if (r == 801) c_second = c;
        if (v_d4.hpos !== prev_h || v_d4.hsync !== prev_hs || v_d4.rgb !== prev_rgb) mis_stab++;
      end
      prev = v_d4.clk_div; prev_h = v_d4.hpos; prev_hs = v_d4.hsync; prev_rgb = v_d4.rgb;
    end
    n_checks++; if (mis_div != 0) begin n_fail++; $display("FAIL div4_clk_div_shape: got %0d bad clks expected 0", mis_div); end
    n_checks++; if (mis_pix != 0) begin n_fail++; $display("FAIL div4_pix_en: got %0d bad clks expected 0", mis_pix); end
    n_checks++; if (mis_pos != 0) begin n_fail++; $display("FAIL div4_pos_track: got %0d bad clks expected 0", mis_pos); end
    n_checks++; if (mis_stab != 0) begin n_fail++; $display("FAIL div4_stable_at_rise: got %0d expected 0", mis_stab); end
    n_checks++; if (c_second - c_first != 3200) begin n_fail++; $display("FAIL div4_line_period: got %0d clks expected 3200", c_second - c_first); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_blanking();
    test_mid_reset();
    test_clkdiv4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
